// File: rtl/order_tx_framer_pkg.sv
// order_tx_pkg: shared types and constants for the order transmit framer.
//   FRAME_LEN : bytes per serialized order frame
//   CHK_IDX   : byte index of the trailing checksum
//   order_t   : 48-bit order record {addr, buysell, timestamp}
//   state_t   : framer FSM states
//   frame_chk : XOR checksum over the six payload bytes of an order
package order_tx_pkg;

  localparam int FRAME_LEN = 8;
  localparam int CHK_IDX   = 7;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  buysell;
    logic [31:0] timestamp;
  } order_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Payload bytes only; the sync byte is deliberately excluded.
  function automatic logic [7:0] frame_chk(input order_t o);
    return o.addr ^ o.buysell ^
           o.timestamp[31:24] ^ o.timestamp[23:16] ^
           o.timestamp[15:8]  ^ o.timestamp[7:0];
  endfunction

endpackage

// File: rtl/order_tx_framer_if.sv
// order_tx_framer_if: byte-stream link between the framer and the transmit MAC.
//   byte_data  : current frame byte
//   byte_valid : byte_data is valid
//   byte_ready : sink accepts on byte_valid & byte_ready
//   byte_last  : final (checksum) byte of a frame
// Modports: master = framer side, slave = sink side.
interface order_tx_framer_if;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;

  modport master (
    output byte_data,
    output byte_valid,
    output byte_last,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    input  byte_last,
    output byte_ready
  );

endinterface

// File: rtl/order_tx_framer_fifo.sv
// order_fifo: synchronous DEPTH x 48-bit order FIFO with first-word fall-through read.
//   clk, reset : clock, synchronous active-high reset (pointers and count only)
//   push, wr_data : write an order; ignored when full
//   pop, rd_data  : rd_data is the head entry; pop ignored when empty
//   full, empty, count : occupancy status
module order_fifo
  import order_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  order_t        wr_data,
  input  logic          pop,
  output order_t        rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  order_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/order_tx_framer.sv
// order_tx_framer: buffers trade orders and serializes each into an 8-byte frame
//   {SYNC_BYTE, addr, buysell, ts[31:24], ts[23:16], ts[15:8], ts[7:0], CHK}.
//   clk, reset     : clock, synchronous active-high reset
//   ord_addr/ord_buysell/ord_timestamp/ord_dv : order strobe, no backpressure
//   tx (master)    : byte stream out with valid/ready/last
//   ord_overflow   : one-cycle pulse, an order was dropped on a full FIFO
//   busy           : FIFO non-empty or a frame in progress (post-edge state)
module order_tx_framer
  import order_tx_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          ord_addr,
  input  logic [7:0]          ord_buysell,
  input  logic [31:0]         ord_timestamp,
  input  logic                ord_dv,
  order_tx_framer_if.master   tx,
  output logic                ord_overflow,
  output logic                busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(FRAME_LEN);

  state_t        state;
  logic [IW-1:0] idx;
  logic [7:0]    frame_b [FRAME_LEN];

  order_t        in_ord;
  order_t        head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          push;
  logic          pop;
  logic          hs;
  logic          at_chk;
  logic          send_n;

  assign in_ord = '{addr: ord_addr, buysell: ord_buysell, timestamp: ord_timestamp};

  // A push on a full FIFO is dropped even when a pop frees a slot this cycle.
  assign push   = ord_dv & ~full;
  assign hs     = (state == SEND) & tx.byte_ready;
  assign at_chk = (idx == IW'(CHK_IDX));
  // Pop either starts a frame from IDLE or chains the next one on the checksum handshake.
  assign pop    = ~empty & ((state == IDLE) | (hs & at_chk));

  assign count_n = count + CW'(push) - CW'(pop);
  assign send_n  = (state == IDLE) ? ~empty : ~(hs & at_chk & empty);

  order_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (in_ord),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Control: FSM, byte index and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      tx.byte_valid <= 1'b0;
      ord_overflow  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      ord_overflow <= ord_dv & full;
      busy         <= send_n | (count_n != '0);
      case (state)
        IDLE: begin
          if (!empty) begin
            state         <= SEND;
            idx           <= '0;
            tx.byte_valid <= 1'b1;
          end
        end
        SEND: begin
          if (tx.byte_ready) begin
            if (at_chk) begin
              idx <= '0;
              if (empty) begin
                state         <= IDLE;
                tx.byte_valid <= 1'b0;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          state         <= IDLE;
          tx.byte_valid <= 1'b0;
        end
      endcase
    end
  end

  // Data: frame register loads on every pop, checksum computed at load time.
  always_ff @(posedge clk) begin
    if (pop) begin
      frame_b[0] <= SYNC_BYTE;
      frame_b[1] <= head.addr;
      frame_b[2] <= head.buysell;
      frame_b[3] <= head.timestamp[31:24];
      frame_b[4] <= head.timestamp[23:16];
      frame_b[5] <= head.timestamp[15:8];
      frame_b[6] <= head.timestamp[7:0];
      frame_b[7] <= frame_chk(head);
    end
  end

  // Decoded from registered state/index only, so both hold steady under a stall.
  assign tx.byte_data = (state == SEND) ? frame_b[idx] : 8'h00;
  assign tx.byte_last = (state == SEND) & at_chk;

endmodule

// File: tb/tb_order_tx_framer.sv
// Testbench for order_tx_framer: queue-based frame model checked every cycle,
// plus directed scenarios with hand-computed literal byte sequences.
module tb_order_tx_framer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ord_addr = 8'h00;
  logic [7:0]  ord_buysell = 8'h00;
  logic [31:0] ord_timestamp = 32'h0;
  logic        ord_dv = 1'b0;
  logic        ord_overflow;
  logic        busy;

  order_tx_framer_if txif ();

  order_tx_framer #(
    .DEPTH     (DEPTH),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ord_addr      (ord_addr),
    .ord_buysell   (ord_buysell),
    .ord_timestamp (ord_timestamp),
    .ord_dv        (ord_dv),
    .tx            (txif),
    .ord_overflow  (ord_overflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [47:0] pend [$];   // orders accepted but not yet framed
  logic [7:0]  cur  [$];   // bytes of the frame in flight still to be accepted
  logic        m_ovf = 1'b0;
  logic        m_full;
  bit          chk_en = 0;
  logic [7:0]  rx [$];     // bytes the sink actually accepted

  task automatic load_next();
    logic [47:0] o;
    logic [7:0]  b [8];
    o = pend.pop_front();
    b[0] = 8'hA5;
    b[1] = o[47:40];
    b[2] = o[39:32];
    b[3] = o[31:24];
    b[4] = o[23:16];
    b[5] = o[15:8];
    b[6] = o[7:0];
    b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
    for (int i = 0; i < 8; i++) cur.push_back(b[i]);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      cur.delete();
      pend.delete();
      m_ovf = 1'b0;
    end else begin
      m_full = (pend.size() == DEPTH);
      m_ovf  = ord_dv && m_full;
      if (cur.size() != 0) begin
        if (txif.byte_ready) begin
          void'(cur.pop_front());
          if (cur.size() == 0 && pend.size() != 0) load_next();
        end
      end else if (pend.size() != 0) begin
        load_next();
      end
      if (ord_dv && !m_full) pend.push_back({ord_addr, ord_buysell, ord_timestamp});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("byte_valid", {31'b0, txif.byte_valid}, {31'b0, cur.size() != 0});
      check("byte_data", {24'b0, txif.byte_data}, (cur.size() != 0) ? {24'b0, cur[0]} : 32'h0);
      check("byte_last", {31'b0, txif.byte_last}, {31'b0, cur.size() == 1});
      check("ord_overflow", {31'b0, ord_overflow}, {31'b0, m_ovf});
      check("busy", {31'b0, busy}, {31'b0, (cur.size() != 0) || (pend.size() != 0)});
      if (!reset && txif.byte_valid && txif.byte_ready) rx.push_back(txif.byte_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] bs, input logic [31:0] ts);
    ord_addr      = a;
    ord_buysell   = bs;
    ord_timestamp = ts;
    ord_dv        = 1'b1;
    step();
    ord_dv        = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy || txif.byte_valid) && n < maxc) begin
      step();
      n++;
    end
    check("idle_timeout", {31'b0, n < maxc}, 32'h1);
  endtask

  task automatic check_frame(input string name, input int off, input logic [63:0] exp);
    check({name, "_len"}, rx.size() >= off + 8, 32'h1);
    if (rx.size() >= off + 8) begin
      for (int i = 0; i < 8; i++)
        check(name, {24'b0, rx[off+i]}, {24'b0, exp[63-8*i -: 8]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    txif.byte_ready = 1'b1;
    reset = 1'b1;
    step();
    step();
    chk_en = 1;

    // Reset state
    check("rst_valid", {31'b0, txif.byte_valid}, 32'h0);
    check("rst_last", {31'b0, txif.byte_last}, 32'h0);
    check("rst_data", {24'b0, txif.byte_data}, 32'h0);
    check("rst_ovf", {31'b0, ord_overflow}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    step();

    // Single order, latency N+2, ready held high
    rx.delete();
    send(8'h03, 8'h01, 32'h12345678);
    check("lat_n1_valid", {31'b0, txif.byte_valid}, 32'h0);
    step();
    check("lat_n2_valid", {31'b0, txif.byte_valid}, 32'h1);
    check("lat_n2_sync", {24'b0, txif.byte_data}, 32'hA5);
    wait_idle(30);
    check_frame("single", 0, 64'hA5_03_01_12_34_56_78_0A);
    check("single_cnt", rx.size(), 32'd8);
    check("single_busy_after", {31'b0, busy}, 32'h0);

    // Backpressure: ready pattern 1,0,0,1 repeating
    rx.delete();
    send(8'h03, 8'h01, 32'h12345678);
    n = 0;
    while ((busy || txif.byte_valid) && n < 80) begin
      txif.byte_ready = (n % 4 == 0) || (n % 4 == 3);
      step();
      n++;
    end
    txif.byte_ready = 1'b1;
    check("bp_timeout", {31'b0, n < 80}, 32'h1);
    check_frame("bp", 0, 64'hA5_03_01_12_34_56_78_0A);
    check("bp_cnt", rx.size(), 32'd8);

    // Burst of 5 with ready low, 6th overflows
    rx.delete();
    txif.byte_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(8'(8'h10 * i), 8'(i), 32'h0);
    check("burst_no_ovf", {31'b0, ord_overflow}, 32'h0);
    send(8'h60, 8'h06, 32'h0);
    check("burst_ovf_6th", {31'b0, ord_overflow}, 32'h1);
    step();
    check("burst_ovf_pulse", {31'b0, ord_overflow}, 32'h0);
    // Release ready; push on the checksum cycle of the first frame (full + pop)
    txif.byte_ready = 1'b1;
    n = 0;
    while (!txif.byte_last && n < 20) begin
      step();
      n++;
    end
    check("burst_last_seen", {31'b0, txif.byte_last}, 32'h1);
    send(8'h70, 8'h07, 32'h0);
    check("full_pop_ovf", {31'b0, ord_overflow}, 32'h1);
    wait_idle(60);
    check("burst_cnt", rx.size(), 32'd40);
    check_frame("burst_f1", 0, 64'hA5_10_01_00_00_00_00_11);
    check_frame("burst_f2", 8, 64'hA5_20_02_00_00_00_00_22);
    check_frame("burst_f5", 32, 64'hA5_50_05_00_00_00_00_55);

    // Reset mid-frame at byte 4 with 2 orders queued
    rx.delete();
    send(8'h01, 8'h02, 32'h0A0B0C0D);
    send(8'h03, 8'h04, 32'h0);
    send(8'h05, 8'h06, 32'h0);
    n = 0;
    while (rx.size() < 4 && n < 20) begin
      step();
      n++;
    end
    check("mid_rx4", rx.size(), 32'd4);
    check("mid_byte4", {24'b0, txif.byte_data}, 32'h0B);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", {31'b0, txif.byte_valid}, 32'h0);
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    step();
    check("mid_stays_idle", {31'b0, txif.byte_valid}, 32'h0);
    rx.delete();
    send(8'h42, 8'h07, 32'hDEADBEEF);
    wait_idle(30);
    check("post_rst_cnt", rx.size(), 32'd8);
    check_frame("post_rst", 0, 64'hA5_42_07_DE_AD_BE_EF_67);

    // Checksum edges
    rx.delete();
    send(8'hFF, 8'hFF, 32'hFFFFFFFF);
    wait_idle(30);
    check_frame("chk_ones", 0, 64'hA5_FF_FF_FF_FF_FF_FF_00);
    rx.delete();
    send(8'h00, 8'h00, 32'h0);
    wait_idle(30);
    check_frame("chk_zero", 0, 64'hA5_00_00_00_00_00_00_00);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
